// File: rtl/mem_line_xfer_if.sv
// Cache-line transfer bus: cache request side, cache data ports and the banked
// memory port, all bundled so the engine and its environment share one handle.
interface mem_line_xfer_if;
    // request from the cache controller
    logic        req_wb;
    logic        req_fill;
    logic [15:0] wb_addr;
    logic [15:0] fill_addr;
    // victim read port and fill write port of the cache
    logic [15:0] wb_data;
    logic [2:0]  wb_offset;
    logic        fill_valid;
    logic [2:0]  fill_offset;
    logic [15:0] fill_data;
    // banked memory port
    logic [15:0] mem_addr;
    logic [15:0] mem_data_out;
    logic        mem_wr;
    logic        mem_rd;
    logic [3:0]  mem_busy;
    logic        mem_stall;
    logic [15:0] mem_data_in;
    logic        mem_err;
    // status
    logic        xfer_busy;
    logic        done;
    logic        err;

    // environment view: cache controller plus memory
    modport master (
        output req_wb, req_fill, wb_addr, fill_addr, wb_data,
               mem_busy, mem_stall, mem_data_in, mem_err,
        input  wb_offset, fill_valid, fill_offset, fill_data,
               mem_addr, mem_data_out, mem_wr, mem_rd,
               xfer_busy, done, err
    );

    // transfer engine view
    modport slave (
        input  req_wb, req_fill, wb_addr, fill_addr, wb_data,
               mem_busy, mem_stall, mem_data_in, mem_err,
        output wb_offset, fill_valid, fill_offset, fill_data,
               mem_addr, mem_data_out, mem_wr, mem_rd,
               xfer_busy, done, err
    );
endinterface

// File: rtl/mem_line_xfer.sv
// Cache line transfer engine: optional 4-word victim writeback followed by an
// optional 4-word line fill against a 4-bank memory with 2-cycle read latency.
module mem_line_xfer (
    input logic           clk,
    input logic           rst,
    mem_line_xfer_if.slave bus
);
    typedef enum logic [2:0] {IDLE, WB, RD, DRAIN, FIN} state_t;

    localparam logic [15:0] LINE_MASK = 16'hFFF8;

    state_t      state;
    logic [1:0]  cnt;         // word index within the line
    logic [15:0] wb_base;
    logic [15:0] fill_base;
    logic        fill_pend;   // a fill follows the writeback
    logic        sticky_err;

    // vld_pipe[0] is this cycle's accepted read; [2] lines up with mem_data_in
    logic [2:0]  vld_pipe;
    logic [2:0]  off_s1;
    logic [2:0]  off_s2;

    logic [15:0] tgt_addr;
    logic        active;
    logic        bank_free;
    logic        issue;

    // Line base is 8-aligned, so adding 0..6 never carries past bit 2.
    assign tgt_addr  = ((state == WB) ? wb_base : fill_base) + {13'd0, cnt, 1'b0};
    assign active    = (state == WB) || (state == RD);
    assign bank_free = !bus.mem_stall && !bus.mem_busy[tgt_addr[2:1]];
    assign issue     = active && bank_free;

    assign bus.mem_wr       = (state == WB) && bank_free;
    assign bus.mem_rd       = (state == RD) && bank_free;
    assign bus.mem_addr     = active ? tgt_addr : 16'd0;
    assign bus.mem_data_out = (state == WB) ? bus.wb_data : 16'd0;
    assign bus.wb_offset    = (state == WB) ? {cnt, 1'b0} : 3'd0;

    assign vld_pipe[0]      = bus.mem_rd;
    assign bus.fill_valid   = vld_pipe[2];
    assign bus.fill_offset  = vld_pipe[2] ? off_s2 : 3'd0;
    assign bus.fill_data    = vld_pipe[2] ? bus.mem_data_in : 16'd0;

    assign bus.xfer_busy    = (state != IDLE);
    assign bus.done         = (state == FIN);
    assign bus.err          = (state == FIN) && sticky_err;

    // Transfer sequencing: accept, walk the words, wait out read latency, finish.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= 2'd0;
            wb_base    <= 16'd0;
            fill_base  <= 16'd0;
            fill_pend  <= 1'b0;
            sticky_err <= 1'b0;
        end else begin
            if (state != IDLE && bus.mem_err)
                sticky_err <= 1'b1;
            case (state)
                IDLE: begin
                    cnt <= 2'd0;
                    if (bus.req_wb || bus.req_fill) begin
                        wb_base    <= bus.wb_addr & LINE_MASK;
                        fill_base  <= bus.fill_addr & LINE_MASK;
                        fill_pend  <= bus.req_fill;
                        sticky_err <= 1'b0;
                        state      <= bus.req_wb ? WB : RD;
                    end
                end
                WB: begin
                    // counter wraps to 0 after the 4th word, ready for RD
                    if (issue) begin
                        cnt <= cnt + 2'd1;
                        if (cnt == 2'd3)
                            state <= fill_pend ? RD : FIN;
                    end
                end
                RD: begin
                    if (issue) begin
                        cnt <= cnt + 2'd1;
                        if (cnt == 2'd3)
                            state <= DRAIN;
                    end
                end
                DRAIN: begin
                    // once stage 1 is empty the last word is being delivered now
                    if (!vld_pipe[1])
                        state <= FIN;
                end
                FIN:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Read-return tracking: offset of each accepted read, aligned with its data.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe[2:1] <= 2'b00;
            off_s1        <= 3'd0;
            off_s2        <= 3'd0;
        end else begin
            vld_pipe[2:1] <= vld_pipe[1:0];
            off_s1        <= {cnt, 1'b0};
            off_s2        <= off_s1;
        end
    end
endmodule

// File: tb/tb_mem_line_xfer.sv
// Directed bench for mem_line_xfer: fill, writeback+fill, bank busy, stall,
// error reporting, mid-transfer reset and top-of-memory line.
module tb_mem_line_xfer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_mis = 0;

    mem_line_xfer_if bus();

    mem_line_xfer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Memory model: returns addr ^ 0xA5A5 two cycles after an accepted read.
    logic        v1 = 1'b0, v2 = 1'b0;
    logic [15:0] a1 = 16'd0, a2 = 16'd0;
    always @(posedge clk) begin
        v1 <= bus.mem_rd;
        a1 <= bus.mem_addr;
        v2 <= v1;
        a2 <= a1;
    end
    assign bus.mem_data_in = v2 ? (a2 ^ 16'hA5A5) : 16'hDEAD;
    // Cache victim read: word value encodes its offset.
    assign bus.wb_data = 16'hB000 | {13'd0, bus.wb_offset};

    // Bank-busy scenario tables (index = cycles after acceptance minus 1)
    int rd39 [10] = '{1, 1, 0, 0, 0, 1, 1, 0, 0, 0};
    int ad39 [10] = '{'h10, 'h12, 'h14, 'h14, 'h14, 'h14, 'h16, -1, -1, -1};
    int fa39 [10] = '{-1, -1, 'h10, 'h12, -1, -1, -1, 'h14, 'h16, -1};
    // Stall + error scenario tables
    int rd40 [8]  = '{1, 1, 0, 1, 1, 0, 0, 0};
    int ad40 [8]  = '{'h2000, 'h2002, 'h2004, 'h2004, 'h2006, -1, -1, -1};
    int fa40 [8]  = '{-1, -1, 'h2000, 'h2002, -1, 'h2004, 'h2006, -1};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // One cycle of output checks; addr/fa of -1 mean "no check"/"no fill".
    task automatic cyc(input string tag, input bit rd, input bit wr, input int addr,
                       input int fa, input bit dn, input bit er);
        chk({tag, " mem_rd"}, 16'(bus.mem_rd), 16'(rd));
        chk({tag, " mem_wr"}, 16'(bus.mem_wr), 16'(wr));
        chk({tag, " done"}, 16'(bus.done), 16'(dn));
        chk({tag, " err"}, 16'(bus.err), 16'(dn & er));
        chk({tag, " fill_valid"}, 16'(bus.fill_valid), 16'(fa >= 0));
        if (addr >= 0)
            chk({tag, " mem_addr"}, bus.mem_addr, 16'(addr));
        if (wr) begin
            chk({tag, " wb_offset"}, 16'(bus.wb_offset), 16'(addr & 7));
            chk({tag, " mem_data_out"}, bus.mem_data_out, 16'hB000 | 16'(addr & 7));
        end
        if (fa >= 0) begin
            chk({tag, " fill_offset"}, 16'(bus.fill_offset), 16'(fa & 7));
            chk({tag, " fill_data"}, bus.fill_data, 16'(fa) ^ 16'hA5A5);
        end
    endtask

    // Unstalled fill starting from IDLE; optionally pokes a request in DRAIN.
    task automatic run_fill(input logic [15:0] base, input bit poke);
        bus.fill_addr = base | 16'h0005;
        bus.req_fill  = 1'b1;
        #1 chk($sformatf("fill %h accept busy", base), 16'(bus.xfer_busy), 16'd0);
        step();
        bus.req_fill = 1'b0;
        for (int i = 0; i < 7; i++) begin
            if (poke) begin
                bus.req_wb  = (i == 4);
                bus.wb_addr = 16'h7770;
            end
            #1;
            cyc($sformatf("fill %h c%0d", base, i + 2), i < 4, 1'b0,
                (i < 4) ? int'(base) + 2 * i : -1,
                (i >= 2 && i < 6) ? int'(base) + 2 * (i - 2) : -1,
                i == 6, 1'b0);
            chk($sformatf("fill %h c%0d busy", base, i + 2), 16'(bus.xfer_busy), 16'd1);
            step();
        end
        bus.req_wb = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            cyc($sformatf("fill %h idle%0d", base, i), 1'b0, 1'b0, -1, -1, 1'b0, 1'b0);
            chk($sformatf("fill %h idle%0d busy", base, i), 16'(bus.xfer_busy), 16'd0);
            step();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_wb    = 1'b0;
        bus.req_fill  = 1'b1;   // must be ignored while in reset
        bus.wb_addr   = 16'd0;
        bus.fill_addr = 16'h1230;
        bus.mem_busy  = 4'd0;
        bus.mem_stall = 1'b0;
        bus.mem_err   = 1'b0;

        // reset state
        step();
        step();
        #1;
        cyc("reset", 1'b0, 1'b0, 0, -1, 1'b0, 1'b0);
        chk("reset busy", 16'(bus.xfer_busy), 16'd0);
        chk("reset wb_offset", 16'(bus.wb_offset), 16'd0);
        chk("reset fill_offset", 16'(bus.fill_offset), 16'd0);
        chk("reset fill_data", bus.fill_data, 16'd0);
        chk("reset mem_data_out", bus.mem_data_out, 16'd0);
        bus.req_fill = 1'b0;
        rst = 1'b0;
        step();

        // plain fill, no stalls
        run_fill(16'h1230, 1'b0);

        // writeback then fill, single done
        bus.req_wb    = 1'b1;
        bus.req_fill  = 1'b1;
        bus.wb_addr   = 16'h4008;
        bus.fill_addr = 16'h0010;
        step();
        bus.req_wb   = 1'b0;
        bus.req_fill = 1'b0;
        for (int i = 0; i < 11; i++) begin
            #1;
            cyc($sformatf("wbfill c%0d", i + 2), i >= 4 && i < 8, i < 4,
                (i < 4) ? 'h4008 + 2 * i : (i < 8) ? 'h10 + 2 * (i - 4) : -1,
                (i >= 6 && i < 10) ? 'h10 + 2 * (i - 6) : -1,
                i == 10, 1'b0);
            step();
        end
        #1 chk("wbfill after busy", 16'(bus.xfer_busy), 16'd0);

        // bank 2 busy for 3 cycles when 0x0014 is next
        bus.req_fill  = 1'b1;
        bus.fill_addr = 16'h0010;
        step();
        bus.req_fill = 1'b0;
        for (int i = 0; i < 10; i++) begin
            bus.mem_busy = (i >= 2 && i <= 4) ? 4'b0100 : 4'b0000;
            #1;
            cyc($sformatf("busy c%0d", i + 2), rd39[i] != 0, 1'b0, ad39[i], fa39[i],
                i == 9, 1'b0);
            step();
        end
        bus.mem_busy = 4'd0;

        // error pulse and one stall cycle during the fill
        bus.req_fill  = 1'b1;
        bus.fill_addr = 16'h2000;
        step();
        bus.req_fill = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bus.mem_err   = (i == 1);
            bus.mem_stall = (i == 2);
            #1;
            cyc($sformatf("err c%0d", i + 2), rd40[i] != 0, 1'b0, ad40[i], fa40[i],
                i == 7, 1'b1);
            step();
        end
        bus.mem_err   = 1'b0;
        bus.mem_stall = 1'b0;

        // writeback-only clears the error; done in cycle 6
        bus.req_wb  = 1'b1;
        bus.wb_addr = 16'h3003;
        step();
        bus.req_wb = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            cyc($sformatf("wbonly c%0d", i + 2), 1'b0, i < 4,
                (i < 4) ? 'h3000 + 2 * i : -1, -1, i == 4, 1'b0);
            step();
        end

        // reset the cycle after the 2nd read issue
        bus.req_fill  = 1'b1;
        bus.fill_addr = 16'h5000;
        step();
        bus.req_fill = 1'b0;
        #1 cyc("rst c2", 1'b1, 1'b0, 'h5000, -1, 1'b0, 1'b0);
        step();
        #1 cyc("rst c3", 1'b1, 1'b0, 'h5002, -1, 1'b0, 1'b0);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            cyc($sformatf("after rst %0d", i), 1'b0, 1'b0, -1, -1, 1'b0, 1'b0);
            chk($sformatf("after rst %0d busy", i), 16'(bus.xfer_busy), 16'd0);
            step();
        end
        run_fill(16'h5008, 1'b0);

        // top-of-memory line, request during DRAIN ignored
        run_fill(16'hFFF8, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule

// File: doc/mem_line_xfer.md
MEM_LINE_XFER -- requirements
Module: mem_line_xfer

Interface
REQ-001 clk  in  1  system clock; all state updates on rising edge.
REQ-002 rst  in  1  synchronous, active-high reset.
REQ-003 req_wb  in  1  write back the victim line at wb_addr; sampled only in IDLE.
REQ-004 req_fill  in  1  fill the line at fill_addr; sampled only in IDLE.
REQ-005 wb_addr, fill_addr  in  16 each  line base addresses; bits [2:0] ignored and treated as 0.
REQ-006 wb_data  in  16  victim word at offset wb_offset, valid in the same cycle (combinational cache read).
REQ-007 wb_offset  out  3  word offset requested from the cache during writeback (0,2,4,6).
REQ-008 mem_addr  out  16  word address to banked memory; bank = mem_addr[2:1].
REQ-009 mem_data_out  out  16  write data to memory.
REQ-010 mem_wr, mem_rd  out  1 each  one-cycle issue strobes; never both high.
REQ-011 mem_busy  in  4  per-bank busy flags.
REQ-012 mem_stall  in  1  global memory stall.
REQ-013 mem_data_in  in  16  read data, valid exactly 2 cycles after the accepted mem_rd.
REQ-014 mem_err  in  1  memory error flag.
REQ-015 fill_valid  out  1  fill_data/fill_offset valid this cycle; cache writes the word.
REQ-016 fill_offset  out  3; fill_data  out  16.
REQ-017 xfer_busy  out  1  high in every non-IDLE state.
REQ-018 done  out  1  one-cycle pulse at end of transfer.
REQ-019 err  out  1  error status, valid with done.

Function
REQ-020 States: IDLE, WB, RD, DRAIN, FIN; encoded in a registered state variable.
REQ-021 IDLE: req_wb -> WB; else req_fill -> RD; else stay. Request addresses and req_fill latched on acceptance.
REQ-022 WB: issue writes at wb_addr+0,+2,+4,+6 in order, word counter 0..3; wb_offset = 2*counter; mem_data_out = wb_data.
REQ-023 An issue (read or write) occurs only in cycles where mem_stall=0 and mem_busy[target bank]=0; otherwise the strobe stays low and the counter holds.
REQ-024 After the 4th write: latched req_fill=1 -> RD with counter cleared; else -> FIN.
REQ-025 RD: issue reads at fill_addr+0,+2,+4,+6 under REQ-023; after the 4th read -> DRAIN.
REQ-026 Each accepted read pushes its offset into a 2-stage pipeline; stage-2 output drives fill_valid/fill_offset, fill_data = mem_data_in.
REQ-027 DRAIN: stay until the pipeline is empty (the 4th fill_valid has been emitted), then -> FIN.
REQ-028 FIN: done=1 for exactly one cycle, -> IDLE; a new request is accepted no earlier than the following cycle.
REQ-029 req_wb and req_fill together in IDLE: writeback completes first, then the fill, with a single done at the end.
REQ-030 Requests arriving outside IDLE are ignored (not queued).
REQ-031 mem_err high in any non-IDLE cycle sets a sticky error; the transfer still completes; err = sticky flag in FIN, cleared on the next accepted request.
REQ-032 Minimum latency with no stalls: fill-only 4 issue cycles + 2 drain cycles + FIN = done in cycle 8 after acceptance; writeback-only done in cycle 6.
REQ-033 Address arithmetic is modulo 2^16; a line base of 0xFFF8 yields 0xFFF8..0xFFFE with no carry out.

Reset
REQ-034 rst=1 at a clock edge: state=IDLE, counter=0, read pipeline cleared, sticky error=0.
REQ-035 During and after reset: mem_wr=mem_rd=fill_valid=done=err=xfer_busy=0; mem_addr, mem_data_out, wb_offset, fill_offset, fill_data=0.
REQ-036 Reset mid-transfer abandons the transfer: no done, and no fill_valid for reads already in flight.

Verification
REQ-037 Fill 0x1230, no stalls -> mem_rd at 0x1230,0x1232,0x1234,0x1236 in consecutive cycles; fill_valid offsets 0,2,4,6 two cycles later; done in cycle 8.
REQ-038 req_wb+req_fill, wb_addr 0x4008, fill_addr 0x0010 -> 4 writes at 0x4008..0x400E with wb_offset 0,2,4,6, then 4 reads at 0x0010..0x0016, one done.
REQ-039 mem_busy[2]=1 for 3 cycles while the next access is 0x0014 -> strobe low and address held for 3 cycles, then issued; all 4 fills still delivered in order.
REQ-040 mem_err pulse during RD -> transfer completes; err=1 with done; next request -> err=0 with its done.
REQ-041 rst asserted the cycle after the 2nd read issue -> no further fill_valid, no done; state IDLE; a new fill then runs normally.
REQ-042 Fill at 0xFFF8 -> reads at 0xFFF8..0xFFFE; new request during DRAIN is ignored.
